fifo_burst_reader: RTL and testbench

//  Read-side master for the dual-clock FIFO: drains a commanded burst of words from the

---
 rtl/fifo_burst_reader_pkg.sv | 12 +
 rtl/fifo_burst_reader_if.sv | 32 +++
 rtl/fifo_skid_buf2.sv | 56 +++++
 rtl/fifo_burst_reader.sv | 107 ++++++++++
 tb/tb_fifo_burst_reader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and defaults for the FIFO burst reader.
package fifo_burst_reader_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO pop port plus valid/ready output stream, seen from the reader (master) side.
interface fifo_burst_reader_if #(
    parameter int unsigned WIDTH = fifo_burst_reader_pkg::DEF_WIDTH
);
    import fifo_burst_reader_pkg::*;

    logic             fifo_rd_en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_rdata,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_rdata,
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface

// File: rtl/fifo_skid_buf2.sv
// Two-entry in-order valid/ready buffer; head entry drives the output.
// The writer must never push into a full buffer unless a pop happens in the same cycle.
module fifo_skid_buf2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       occ_q;
    logic             pop;

    assign pop       = (occ_q != 2'd0) && out_ready;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign occupancy = occ_q;

    // Entry storage and occupancy: push fills the first free slot, pop shifts tail to head.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            unique case ({in_valid, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_q <= in_data;
                    else               tail_q <= in_data;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= in_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master: pops a commanded number of words from the FIFO and
// streams them out through a 2-entry buffer that hides the FIFO read latency.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_BURST = 255,
    parameter int unsigned LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    burst_len,
    output logic                busy,
    output logic                done,
    output logic [LEN_W-1:0]    rd_count,
    fifo_burst_reader_if.master bus
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued_q;
    logic             inflight_q;
    logic             zdone_q;
    logic [1:0]       occ;
    logic [2:0]       slots;
    logic             xfer;
    logic             accept;
    logic             rd_en;
    logic             drain_done;

    fifo_skid_buf2 #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .res_n     (res_n),
        .in_valid  (inflight_q),
        .in_data   (bus.fifo_rdata),
        .out_valid (bus.m_valid),
        .out_data  (bus.m_data),
        .out_ready (bus.m_ready),
        .occupancy (occ)
    );

    assign xfer = bus.m_valid && bus.m_ready;
    // Slots committed to buffered or in-flight words; a word leaving this cycle
    // frees its slot in time, which is what lets pops run back to back.
    assign slots = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, xfer};

    assign bus.fifo_rd_en = rd_en;
    assign busy           = (state_q != ST_IDLE);
    assign done           = drain_done || zdone_q;

    // State register.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state, start acceptance, pop strobe and end-of-burst detection.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        rd_en      = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (burst_len != '0) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_en = !bus.fifo_empty && (issued_q < len_q) && (slots < 3'd2);
                if (issued_q == len_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((occ == 2'd0) && !inflight_q) begin
                    drain_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst length latch, issue/in-flight tracking, delivered-word count, zero-length done.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            zdone_q    <= 1'b0;
            rd_count   <= '0;
        end else begin
            inflight_q <= rd_en;
            zdone_q    <= accept && (burst_len == '0);
            if (accept) begin
                len_q    <= burst_len;
                issued_q <= '0;
            end else if (rd_en) begin
                issued_q <= issued_q + LEN_W'(1);
            end
            if (accept)    rd_count <= '0;
            else if (xfer) rd_count <= rd_count + LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO read port.
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_BURST = 255;
    localparam int unsigned LEN_W     = 8;

    logic             clk = 1'b0;
    logic             res_n;
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] rd_count;

    fifo_burst_reader_if #(.WIDTH(WIDTH)) bus ();

    fifo_burst_reader #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .rd_count  (rd_count),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // FIFO read port model: registered read data one cycle after the pop.
    logic [7:0] mem [0:1023];
    int wptr = 0;
    int rptr = 0;
    assign bus.fifo_empty = (wptr == rptr);
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rdata <= mem[rptr[9:0]];
            rptr           <= rptr + 1;
        end
    end

    // Output monitor, sampled on the falling edge.
    logic [7:0] rx [$];
    int pop_cyc [$];
    int done_cnt = 0, pop_cnt = 0, uflow_cnt = 0, cyc = 0, done_rx_size = 0;
    always @(negedge clk) begin
        cyc++;
        if (res_n) begin
            if (bus.m_valid && bus.m_ready) rx.push_back(bus.m_data);
            if (done) begin
                done_cnt++;
                done_rx_size = rx.size();
            end
            if (bus.fifo_rd_en) begin
                pop_cnt++;
                pop_cyc.push_back(cyc);
            end
            if (bus.fifo_rd_en && bus.fifo_empty) uflow_cnt++;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [7:0] d);
        mem[wptr[9:0]] = d;
        wptr = wptr + 1;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] len);
        start     = 1'b1;
        burst_len = len;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < budget) begin
            tick(1);
            i++;
        end
        check({tag, " done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] base, input int n);
        logic [7:0] e;
        check({tag, " rx_count"}, 32'(rx.size()), 32'(n));
        for (int i = 0; i < n && i < rx.size(); i++) begin
            e = base + 8'(i);
            check($sformatf("%s rx[%0d]", tag, i), 32'(rx[i]), 32'(e));
        end
    endtask

    int t, d0, p0, errs;
    logic [7:0] held;
    logic       stable;

    initial begin
        res_n       = 1'b0;
        start       = 1'b0;
        burst_len   = '0;
        bus.m_ready = 1'b0;
        tick(2);
        check("reset busy",     32'(busy),           32'd0);
        check("reset done",     32'(done),           32'd0);
        check("reset rd_en",    32'(bus.fifo_rd_en), 32'd0);
        check("reset m_valid",  32'(bus.m_valid),    32'd0);
        check("reset m_data",   32'(bus.m_data),     32'd0);
        check("reset rd_count", 32'(rd_count),       32'd0);
        res_n = 1'b1;
        tick(2);

        // 1: preloaded burst of 4 at full rate
        for (int i = 0; i < 4; i++) fifo_write(8'hA0 + 8'(i));
        bus.m_ready = 1'b1;
        rx.delete();
        pop_cyc.delete();
        d0 = done_cnt;
        p0 = pop_cnt;
        do_start(8'd4);
        t = 0;
        while (!bus.m_valid && t < 20) begin
            tick(1);
            t++;
        end
        check("t1 start_to_valid", 32'(t + 1), 32'd3);
        wait_done("t1", 50);
        check("t1 done_at_word", 32'(done_rx_size), 32'd4);
        tick(4);
        check_rx("t1", 8'hA0, 4);
        check("t1 pops",     32'(pop_cnt - p0),  32'd4);
        check("t1 pops_consecutive", 32'(pop_cyc.size() == 4 ? pop_cyc[3] - pop_cyc[0] : -1), 32'd3);
        check("t1 done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t1 rd_count", 32'(rd_count),      32'd4);
        check("t1 busy",     32'(busy),          32'd0);

        // 2: FIFO runs dry mid-burst, then refills
        rx.delete();
        d0 = done_cnt;
        fifo_write(8'hB0);
        fifo_write(8'hB1);
        do_start(8'd6);
        tick(20);
        check("t2 stalled rx",       32'(rx.size()), 32'd2);
        check("t2 stalled rd_count", 32'(rd_count),  32'd2);
        check("t2 stalled busy",     32'(busy),      32'd1);
        for (int i = 2; i < 6; i++) fifo_write(8'hB0 + 8'(i));
        wait_done("t2", 50);
        tick(3);
        check_rx("t2", 8'hB0, 6);
        check("t2 done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t2 rd_count", 32'(rd_count),      32'd6);
        check("t2 underflow", 32'(uflow_cnt),    32'd0);

        // 3: consumer back-pressure right from the first word
        rx.delete();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_write(8'hC0 + 8'(i));
        p0 = pop_cnt;
        do_start(8'd8);
        t = 0;
        while (!bus.m_valid && t < 20) begin
            tick(1);
            t++;
        end
        check("t3 m_valid", 32'(bus.m_valid), 32'd1);
        held   = bus.m_data;
        stable = 1'b1;
        repeat (10) begin
            tick(1);
            if (bus.m_data !== held || bus.m_valid !== 1'b1) stable = 1'b0;
        end
        check("t3 held_data",   32'(held),         32'hC0);
        check("t3 stable",      32'(stable),       32'd1);
        check("t3 outstanding", 32'(pop_cnt - p0), 32'd2);
        bus.m_ready = 1'b1;
        wait_done("t3", 50);
        tick(3);
        check_rx("t3", 8'hC0, 8);
        check("t3 rd_count", 32'(rd_count), 32'd8);

        // 4: maximum burst with alternating ready
        rx.delete();
        for (int i = 0; i < 255; i++) fifo_write(8'(i) ^ 8'h3C);
        d0 = done_cnt;
        do_start(8'd255);
        t = 0;
        while (done_cnt == d0 && t < 2000) begin
            bus.m_ready = ~bus.m_ready;
            tick(1);
            t++;
        end
        bus.m_ready = 1'b1;
        check("t4 done_seen",    32'(done_cnt != d0), 32'd1);
        check("t4 done_at_word", 32'(done_rx_size),   32'd255);
        tick(3);
        errs = 0;
        for (int i = 0; i < 255 && i < rx.size(); i++)
            if (rx[i] !== (8'(i) ^ 8'h3C)) errs++;
        check("t4 rx_count",    32'(rx.size()),      32'd255);
        check("t4 data_errors", 32'(errs),           32'd0);
        check("t4 rd_count",    32'(rd_count),       32'd255);
        check("t4 done_cnt",    32'(done_cnt - d0),  32'd1);
        check("t4 underflow",   32'(uflow_cnt),      32'd0);

        // 5: reset while the third word is presented, then a fresh burst
        for (int i = 0; i < 8; i++) fifo_write(8'h50 + 8'(i));
        rx.delete();
        do_start(8'd8);
        t = 0;
        while (t < 30) begin
            @(negedge clk);
            if (bus.m_valid && bus.m_data == 8'h52) break;
            t++;
        end
        check("t5 reached_word3", 32'(t < 30), 32'd1);
        #1 res_n = 1'b0;
        d0 = done_cnt;
        #1;
        check("t5 rst busy",     32'(busy),           32'd0);
        check("t5 rst done",     32'(done),           32'd0);
        check("t5 rst rd_en",    32'(bus.fifo_rd_en), 32'd0);
        check("t5 rst m_valid",  32'(bus.m_valid),    32'd0);
        check("t5 rst m_data",   32'(bus.m_data),     32'd0);
        check("t5 rst rd_count", 32'(rd_count),       32'd0);
        tick(3);
        res_n = 1'b1;
        tick(3);
        check("t5 no_abort_done", 32'(done_cnt - d0), 32'd0);
        rx.delete();
        do_start(8'd2);
        wait_done("t5", 50);
        tick(3);
        check_rx("t5", 8'h54, 2);
        check("t5 rd_count", 32'(rd_count), 32'd2);

        // 6: zero-length burst, then a start issued while busy
        rx.delete();
        p0 = pop_cnt;
        d0 = done_cnt;
        do_start(8'd0);
        check("t6 zero done",  32'(done),           32'd1);
        check("t6 zero busy",  32'(busy),           32'd0);
        check("t6 zero rd_en", 32'(bus.fifo_rd_en), 32'd0);
        tick(1);
        check("t6 zero done_pulse", 32'(done),          32'd0);
        check("t6 zero pops",       32'(pop_cnt - p0),  32'd0);
        check("t6 zero done_cnt",   32'(done_cnt - d0), 32'd1);
        d0 = done_cnt;
        do_start(8'd2);
        check("t6 busy", 32'(busy), 32'd1);
        do_start(8'd5);
        wait_done("t6", 50);
        tick(5);
        check_rx("t6", 8'h56, 2);
        check("t6 pops",     32'(pop_cnt - p0),  32'd2);
        check("t6 done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t6 rd_count", 32'(rd_count),      32'd2);
        check("t6 idle",     32'(busy),          32'd0);
        check("t6 underflow", 32'(uflow_cnt),    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
